// File: rtl/stage_fe_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
//   master (fetch): req, addr out; ready, valid, data in
//   slave  (imem) : req, addr in;  ready, valid, data out
interface stage_fe_if #(
  parameter int INST_W      = 32,
  parameter int INST_ADDR_W = 16
);
  logic                   req;
  logic [INST_ADDR_W-1:0] addr;
  logic                   ready;
  logic                   valid;
  logic [INST_W-1:0]      data;

  modport master (output req, addr, input ready, valid, data);
  modport slave  (input req, addr, output ready, valid, data);
endinterface

// File: rtl/stage_fe.sv
// Instruction-fetch stage. Holds the word-addressed fetch PC, keeps at most
// two credits (outstanding requests + buffered words), tags each request
// with an epoch bit so wrong-path responses after a redirect are dropped,
// and feeds decode through registered out_inst/out_pc/out_flush.
// Ports:
//   clk, rst            clock, async active-high reset
//   en                  stage enable (no requests, outputs hold when low)
//   stall               decode backpressure (outputs hold)
//   redirect/_pc        taken branch/jump from execute
//   imem                instruction-memory bus (master side)
//   out_inst/pc/flush   instruction to decode; flush marks a bubble
module stage_fe #(
  parameter int                     INST_W      = 32,
  parameter int                     INST_ADDR_W = 16,
  parameter logic [INST_ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [INST_W-1:0]      NOP_INST    = 'h00000013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [INST_ADDR_W-1:0] redirect_pc,
  stage_fe_if.master             imem,
  output logic [INST_W-1:0]      out_inst,
  output logic [INST_ADDR_W-1:0] out_pc,
  output logic                   out_flush
);
  typedef struct packed {
    logic                   ep;
    logic [INST_ADDR_W-1:0] pc;
  } tag_t;

  typedef struct packed {
    logic [INST_W-1:0]      inst;
    logic [INST_ADDR_W-1:0] pc;
  } ent_t;

  logic [INST_ADDR_W-1:0] fetch_pc;
  logic                   epoch;
  tag_t [1:0]             tag_q, tag_d;
  logic [1:0]             tag_cnt, tag_cnt_d;
  ent_t [1:0]             buf_q, buf_d;
  logic [1:0]             buf_cnt, buf_cnt_d;
  logic [2:0]             credits;
  logic                   accept, resp, resp_ok, adv, avail, pop_buf, bypass;
  ent_t                   head, resp_ent;

  // Credits = outstanding tags + buffered words; never exceeds 2.
  assign credits   = {1'b0, tag_cnt} + {1'b0, buf_cnt};
  assign imem.req  = !rst && en && !redirect && (credits < 3'd2);
  assign imem.addr = fetch_pc;
  assign accept    = imem.req && imem.ready;

  // Responses with nothing outstanding are ignored. A response in the
  // redirect cycle is wrong-path by construction and is dropped.
  assign resp     = imem.valid && (tag_cnt != 2'd0);
  assign resp_ok  = resp && (tag_q[0].ep == epoch) && !redirect;
  assign resp_ent = '{inst: imem.data, pc: tag_q[0].pc};

  // An arriving word may go straight to the output when the buffer is
  // empty; this keeps a 1-cycle memory at one instruction per cycle within
  // the 2-credit budget (a word holds its credit for only one cycle).
  assign adv     = en && !stall && !redirect;
  assign avail   = (buf_cnt != 2'd0) || resp_ok;
  assign head    = (buf_cnt != 2'd0) ? buf_q[0] : resp_ent;
  assign pop_buf = adv && (buf_cnt != 2'd0);
  assign bypass  = adv && (buf_cnt == 2'd0) && resp_ok;

  // In-order epoch/address tag FIFO, head at index 0.
  always_comb begin
    tag_d     = tag_q;
    tag_cnt_d = tag_cnt;
    if (resp) begin
      tag_d[0]  = tag_q[1];
      tag_cnt_d = tag_cnt - 2'd1;
    end
    if (accept) begin
      tag_d[tag_cnt_d[0]] = '{ep: epoch, pc: fetch_pc};
      tag_cnt_d           = tag_cnt_d + 2'd1;
    end
  end

  // Response buffer, head at index 0; redirect flushes it.
  always_comb begin
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt;
    if (pop_buf) begin
      buf_d[0]  = buf_q[1];
      buf_cnt_d = buf_cnt - 2'd1;
    end
    if (resp_ok && !bypass) begin
      buf_d[buf_cnt_d[0]] = resp_ent;
      buf_cnt_d           = buf_cnt_d + 2'd1;
    end
    if (redirect) buf_cnt_d = 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      epoch     <= 1'b0;
      tag_q     <= '0;
      tag_cnt   <= 2'd0;
      buf_q     <= '0;
      buf_cnt   <= 2'd0;
      out_inst  <= NOP_INST;
      out_pc    <= RESET_PC;
      out_flush <= 1'b1;
    end else begin
      tag_q   <= tag_d;
      tag_cnt <= tag_cnt_d;
      buf_q   <= buf_d;
      buf_cnt <= buf_cnt_d;
      if (redirect) begin
        fetch_pc  <= redirect_pc;
        epoch     <= ~epoch;
        out_flush <= 1'b1;
        out_inst  <= NOP_INST;
      end else begin
        if (accept) fetch_pc <= fetch_pc + INST_ADDR_W'(1);
        if (adv) begin
          if (avail) begin
            out_inst  <= head.inst;
            out_pc    <= head.pc;
            out_flush <= 1'b0;
          end else begin
            out_inst  <= NOP_INST;
            out_flush <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_stage_fe.sv
module tb_stage_fe;
  localparam int          IW  = 32;
  localparam int          AW  = 8;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [IW-1:0] out_inst;
  logic [AW-1:0] out_pc;
  logic          out_flush;

  int nvec = 0;
  int nerr = 0;

  stage_fe_if #(.INST_W(IW), .INST_ADDR_W(AW)) bus ();

  stage_fe #(.INST_W(IW), .INST_ADDR_W(AW), .RESET_PC(8'h00), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(bus.master),
    .out_inst(out_inst), .out_pc(out_pc), .out_flush(out_flush)
  );

  always #5 clk = ~clk;

  // Memory model: in-order, fixed latency lat (>=1), data = addr + 0x100.
  // A request accepted at edge E is presented after edge E+lat-1 and is
  // captured by the DUT at edge E+lat.
  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } mreq_t;
  mreq_t         mq[$];
  int            lat = 1;
  int            ecnt = 0;
  logic          mem_ready = 1'b1;
  logic          acc_pending = 1'b0;
  logic [AW-1:0] acc_addr = '0;

  assign bus.ready = mem_ready;

  always @(negedge clk) begin
    acc_pending = bus.req && bus.ready;
    acc_addr    = bus.addr;
  end

  always @(posedge clk) begin
    #1;
    ecnt++;
    if (rst) begin
      mq.delete();
      bus.valid = 1'b0;
      bus.data  = '0;
    end else begin
      if (bus.valid) void'(mq.pop_front());
      if (acc_pending) mq.push_back('{acc_addr, ecnt + lat - 1});
      if (mq.size() > 0 && mq[0].due <= ecnt) begin
        bus.valid = 1'b1;
        bus.data  = 32'h100 + 32'(mq[0].addr);
      end else begin
        bus.valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Lands 2 time units after a rising edge: outputs of that edge are stable.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1; en = 1'b0; stall = 1'b0; redirect = 1'b0; mem_ready = 1'b1;
    lat = l;
    step(); step();
    rst = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; lat = 1;
    step(); step();
    nvec++;
    if ({out_flush, out_pc, out_inst} !== {1'b1, 8'h00, NOP}) begin
      nerr++;
      $display("FAIL reset_out got f=%b pc=%h i=%h exp f=1 pc=00 i=%h", out_flush, out_pc, out_inst, NOP);
    end
    nvec++;
    if ({bus.req, bus.addr} !== {1'b0, 8'h00}) begin
      nerr++;
      $display("FAIL reset_req got req=%b addr=%h exp req=0 addr=00", bus.req, bus.addr);
    end
  endtask

  // Leaves the DUT two time units after the edge where out_pc=5.
  task automatic test_stream();
    do_reset(1);
    step();
    nvec++;
    if (out_flush !== 1'b1) begin
      nerr++; $display("FAIL stream_first_bubble got f=%b exp 1", out_flush);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      nvec++;
      if ({out_flush, out_pc, out_inst} !== {1'b0, 8'(i), 32'h100 + 32'(i)}) begin
        nerr++;
        $display("FAIL stream[%0d] got f=%b pc=%h i=%h exp f=0 pc=%h i=%h", i, out_flush, out_pc, out_inst, 8'(i), 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_stall_hold();
    stall = 1'b1;
    nvec++;
    if (bus.req !== 1'b1) begin
      nerr++; $display("FAIL stall_req_pre got %b exp 1", bus.req);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if ({out_flush, out_pc, out_inst, bus.req} !== {1'b0, 8'h05, 32'h105, 1'b0}) begin
        nerr++;
        $display("FAIL stall_hold[%0d] got f=%b pc=%h i=%h req=%b exp f=0 pc=05 i=105 req=0", i, out_flush, out_pc, out_inst, bus.req);
      end
    end
    stall = 1'b0;
    for (int i = 6; i < 9; i++) begin
      step();
      nvec++;
      if ({out_flush, out_pc, out_inst} !== {1'b0, 8'(i), 32'h100 + 32'(i)}) begin
        nerr++;
        $display("FAIL stall_resume[%0d] got f=%b pc=%h i=%h exp f=0 pc=%h", i, out_flush, out_pc, out_inst, 8'(i));
      end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset(2);
    step(); step();
    nvec++;
    if (bus.req !== 1'b0) begin
      nerr++; $display("FAIL rdi_credit_full got req=%b exp 0", bus.req);
    end
    redirect = 1'b1; redirect_pc = 8'h40;
    step();
    redirect = 1'b0;
    #1;
    nvec++;
    if ({bus.req, bus.addr} !== {1'b1, 8'h40}) begin
      nerr++; $display("FAIL rdi_recover got req=%b addr=%h exp req=1 addr=40", bus.req, bus.addr);
    end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if ({out_flush, out_pc, out_inst} !== {1'b1, 8'h00, NOP}) begin
        nerr++;
        $display("FAIL rdi_bubble[%0d] got f=%b pc=%h i=%h exp f=1 pc=00 i=%h", i, out_flush, out_pc, out_inst, NOP);
      end
      step();
    end
    nvec++;
    if ({out_flush, out_pc, out_inst} !== {1'b0, 8'h40, 32'h140}) begin
      nerr++;
      $display("FAIL rdi_target got f=%b pc=%h i=%h exp f=0 pc=40 i=140", out_flush, out_pc, out_inst);
    end
  endtask

  task automatic test_redirect_coincident();
    do_reset(1);
    step(); step(); step();
    // Response for address 2 is on the bus in this cycle.
    redirect = 1'b1; redirect_pc = 8'h20;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if ({out_flush, out_pc, out_inst} !== {1'b1, 8'h01, NOP}) begin
        nerr++;
        $display("FAIL rdc_drop[%0d] got f=%b pc=%h i=%h exp f=1 pc=01", i, out_flush, out_pc, out_inst);
      end
      step();
    end
    nvec++;
    if ({out_flush, out_pc, out_inst} !== {1'b0, 8'h20, 32'h120}) begin
      nerr++;
      $display("FAIL rdc_target got f=%b pc=%h i=%h exp f=0 pc=20 i=120", out_flush, out_pc, out_inst);
    end
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b0;
    step();
    nvec++;
    if ({out_flush, out_pc, out_inst} !== {1'b0, 8'h21, 32'h121}) begin
      nerr++; $display("FAIL bp_last got f=%b pc=%h i=%h exp f=0 pc=21", out_flush, out_pc, out_inst);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if ({out_flush, out_pc, out_inst, bus.req, bus.addr} !== {1'b1, 8'h21, NOP, 1'b1, 8'h22}) begin
        nerr++;
        $display("FAIL bp_hold[%0d] got f=%b pc=%h i=%h req=%b addr=%h exp f=1 pc=21 req=1 addr=22", i, out_flush, out_pc, out_inst, bus.req, bus.addr);
      end
    end
    mem_ready = 1'b1;
    step();
    nvec++;
    if (out_flush !== 1'b1) begin
      nerr++; $display("FAIL bp_gap got f=%b exp 1", out_flush);
    end
    step();
    nvec++;
    if ({out_flush, out_pc, out_inst} !== {1'b0, 8'h22, 32'h122}) begin
      nerr++; $display("FAIL bp_resume got f=%b pc=%h i=%h exp f=0 pc=22 i=122", out_flush, out_pc, out_inst);
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 8'hFF;
    step();
    redirect = 1'b0;
    #1;
    nvec++;
    if ({out_flush, bus.req, bus.addr} !== {1'b1, 1'b1, 8'hFF}) begin
      nerr++; $display("FAIL wrap_req got f=%b req=%b addr=%h exp f=1 req=1 addr=ff", out_flush, bus.req, bus.addr);
    end
    step(); step();
    nvec++;
    if ({out_flush, out_pc, out_inst} !== {1'b0, 8'hFF, 32'h1FF}) begin
      nerr++; $display("FAIL wrap_top got f=%b pc=%h i=%h exp f=0 pc=ff i=1ff", out_flush, out_pc, out_inst);
    end
    step();
    nvec++;
    if ({out_flush, out_pc, out_inst} !== {1'b0, 8'h00, 32'h100}) begin
      nerr++; $display("FAIL wrap_zero got f=%b pc=%h i=%h exp f=0 pc=00 i=100", out_flush, out_pc, out_inst);
    end
  endtask

  task automatic test_enable_low();
    do_reset(2);
    step(); step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if ({out_flush, out_pc, out_inst, bus.req} !== {1'b1, 8'h00, NOP, 1'b0}) begin
        nerr++;
        $display("FAIL en_hold[%0d] got f=%b pc=%h i=%h req=%b exp f=1 pc=00 req=0", i, out_flush, out_pc, out_inst, bus.req);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      nvec++;
      if ({out_flush, out_pc, out_inst} !== {1'b0, 8'(i), 32'h100 + 32'(i)}) begin
        nerr++;
        $display("FAIL en_drain[%0d] got f=%b pc=%h i=%h exp f=0 pc=%h", i, out_flush, out_pc, out_inst, 8'(i));
      end
    end
    step();
    nvec++;
    if ({out_flush, out_pc, out_inst} !== {1'b1, 8'h01, NOP}) begin
      nerr++; $display("FAIL en_gap got f=%b pc=%h i=%h exp f=1 pc=01", out_flush, out_pc, out_inst);
    end
    step();
    nvec++;
    if ({out_flush, out_pc, out_inst} !== {1'b0, 8'h02, 32'h102}) begin
      nerr++; $display("FAIL en_next got f=%b pc=%h i=%h exp f=0 pc=02 i=102", out_flush, out_pc, out_inst);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    nvec++;
    if ({out_flush, out_pc, out_inst, bus.req} !== {1'b1, 8'h00, NOP, 1'b0}) begin
      nerr++;
      $display("FAIL reset_mid got f=%b pc=%h i=%h req=%b exp f=1 pc=00 req=0", out_flush, out_pc, out_inst, bus.req);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_inflight();
    test_redirect_coincident();
    test_backpressure();
    test_wrap();
    test_enable_low();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
